// File: rtl/reg_file8x16.sv
// reg_file8x16: eight-entry architectural register file with a pending-write
// scoreboard. R7 doubles as the program counter (load / increment / writeback).
// Read ports are combinational; all state changes happen on the rising clock
// edge. The reset input is asynchronous and active-low.
// Optional feature macro: REG_FILE_BYPASS_EN forwards same-cycle writeback
// data and ready status to the read ports. Without it, reads return stored
// values only.
module reg_file8x16 #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   PC_RESET = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ra_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic             ra_ready,
    input  logic [2:0]       rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             write,
    input  logic [2:0]       issue_addr,
    input  logic             issue,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             pc_write,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc_out,
    output logic [7:0]       busy
);

    logic [7:0][WIDTH-1:0] regs_r;
    logic [7:0][WIDTH-1:0] regs_nxt_s;
    logic [7:0]            busy_r;
    logic [7:0]            busy_nxt_s;
    logic [WIDTH-1:0]      pc_plus1_s;
    logic                  byp_a_s;
    logic                  byp_b_s;
    logic                  issue_hit_s;
    logic [WIDTH-1:0]      ra_data_s;
    logic                  ra_ready_s;
    logic [WIDTH-1:0]      rb_data_s;
    logic                  rb_ready_s;

    // Strobes are compared against an explicit 0 so an X/high strobe never
    // updates state.
    assign pc_plus1_s  = regs_r[7] + {{(WIDTH-1){1'b0}}, 1'b1};
    assign issue_hit_s = (issue == 1'b0) && (issue_addr == wr_addr);

`ifdef REG_FILE_BYPASS_EN
    // Forwarding into R7 is suppressed while a PC load owns that register.
    assign byp_a_s = (write == 1'b0) && (ra_addr == wr_addr) &&
                     ((wr_addr != 3'd7) || (pc_write == 1'b1));
    assign byp_b_s = (write == 1'b0) && (rb_addr == wr_addr) &&
                     ((wr_addr != 3'd7) || (pc_write == 1'b1));
`else
    assign byp_a_s = 1'b0;
    assign byp_b_s = 1'b0;
`endif

    // Next-state for the data registers; R7 applies load > writeback > increment.
    always_comb begin
        regs_nxt_s = regs_r;
        for (int i = 0; i < 7; i++) begin
            if ((write == 1'b0) && (wr_addr == 3'(i))) begin
                regs_nxt_s[i] = wr_data;
            end else begin
                regs_nxt_s[i] = regs_r[i];
            end
        end
        if (pc_write == 1'b0) begin
            regs_nxt_s[7] = pc_in;
        end else if ((write == 1'b0) && (wr_addr == 3'd7)) begin
            regs_nxt_s[7] = wr_data;
        end else if (pc_inc == 1'b0) begin
            regs_nxt_s[7] = pc_plus1_s;
        end else begin
            regs_nxt_s[7] = regs_r[7];
        end
    end

    // Next-state for the scoreboard; a new issue beats a retiring write to the same index.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < 8; i++) begin
            if ((issue == 1'b0) && (issue_addr == 3'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if ((write == 1'b0) && (wr_addr == 3'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // State registers with asynchronous clear; R7 reloads the PC reset vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 7; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            regs_r[7] <= PC_RESET;
            busy_r    <= 8'h00;
        end else begin
            regs_r <= regs_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    // Read port A: stored value, or forwarded writeback when bypass hits.
    always_comb begin
        if (byp_a_s) begin
            ra_data_s  = wr_data;
            ra_ready_s = ~issue_hit_s;
        end else begin
            ra_data_s  = regs_r[ra_addr];
            ra_ready_s = ~busy_r[ra_addr];
        end
    end

    // Read port B: stored value, or forwarded writeback when bypass hits.
    always_comb begin
        if (byp_b_s) begin
            rb_data_s  = wr_data;
            rb_ready_s = ~issue_hit_s;
        end else begin
            rb_data_s  = regs_r[rb_addr];
            rb_ready_s = ~busy_r[rb_addr];
        end
    end

    assign ra_data  = ra_data_s;
    assign ra_ready = ra_ready_s;
    assign rb_data  = rb_data_s;
    assign rb_ready = rb_ready_s;
    assign pc_out   = regs_r[7];
    assign busy     = busy_r;

endmodule

// File: tb/tb_reg_file8x16.sv
// Self-checking bench for reg_file8x16. A behavioural model computes expected
// outputs when stimulus is driven; they are queued and compared once the DUT
// output is due (same cycle for combinational reads, after the edge otherwise).
module tb_reg_file8x16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ra_addr, rb_addr, wr_addr, issue_addr;
    logic [15:0] ra_data, rb_data, wr_data, pc_in, pc_out;
    logic        ra_ready, rb_ready, write, issue, pc_write, pc_inc;
    logic [7:0]  busy;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mreg [8];
    logic [7:0]  mbusy;

    always #5 clk = ~clk;

    reg_file8x16 dut (
        .clk(clk), .reset(reset),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_ready(ra_ready),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_ready(rb_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .write(write),
        .issue_addr(issue_addr), .issue(issue),
        .pc_in(pc_in), .pc_write(pc_write), .pc_inc(pc_inc),
        .pc_out(pc_out), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int unsigned sel);
        case (sel)
            0:       observe = ra_data;
            1:       observe = {15'd0, ra_ready};
            2:       observe = rb_data;
            3:       observe = {15'd0, rb_ready};
            4:       observe = pc_out;
            default: observe = {8'd0, busy};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) mreg[i] = 16'h0000;
        mreg[7] = 16'h0000;
        mbusy   = 8'h00;
    endtask

    // Queue the expected outputs for the current model state and read addresses.
    task automatic push_expect(input string tag, input bit live);
        logic [15:0] ea, eb;
        logic        ra, rb;
        ea = mreg[ra_addr]; ra = ~mbusy[ra_addr];
        eb = mreg[rb_addr]; rb = ~mbusy[rb_addr];
`ifdef REG_FILE_BYPASS_EN
        if (live && write === 1'b0 && (wr_addr != 3'd7 || pc_write === 1'b1)) begin
            if (ra_addr == wr_addr) begin
                ea = wr_data; ra = !(issue === 1'b0 && issue_addr == wr_addr);
            end
            if (rb_addr == wr_addr) begin
                eb = wr_data; rb = !(issue === 1'b0 && issue_addr == wr_addr);
            end
        end
`endif
        sb.push_back('{{tag, "/ra_data"}, 0, ea});
        sb.push_back('{{tag, "/ra_ready"}, 1, {15'd0, ra}});
        sb.push_back('{{tag, "/rb_data"}, 2, eb});
        sb.push_back('{{tag, "/rb_ready"}, 3, {15'd0, rb}});
        sb.push_back('{{tag, "/pc_out"}, 4, mreg[7]});
        sb.push_back('{{tag, "/busy"}, 5, {8'd0, mbusy}});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        write = 1'b1; issue = 1'b1; pc_write = 1'b1; pc_inc = 1'b1;
    endtask

    // Check combinational outputs for the inputs currently driven.
    task automatic check_now(input string tag);
        push_expect(tag, 1'b1);
        #1;
        drain();
    endtask

    // Advance the model by one edge, queue the post-edge view, then clock and compare.
    task automatic clock_step(input string tag);
        logic [15:0] n7;
        logic [7:0]  nb;
        nb = mbusy;
        if (write === 1'b0) nb[wr_addr] = 1'b0;
        if (issue === 1'b0) nb[issue_addr] = 1'b1;
        if (pc_write === 1'b0)                       n7 = pc_in;
        else if (write === 1'b0 && wr_addr == 3'd7)  n7 = wr_data;
        else if (pc_inc === 1'b0)                    n7 = mreg[7] + 16'd1;
        else                                         n7 = mreg[7];
        if (write === 1'b0 && wr_addr != 3'd7) mreg[wr_addr] = wr_data;
        mreg[7] = n7;
        mbusy   = nb;
        push_expect(tag, 1'b0);
        @(posedge clk);
        #1 idle();
        #1 drain();
    endtask

    initial begin
        reset = 1'b0; idle();
        ra_addr = 3'd0; rb_addr = 3'd7; wr_addr = 3'd0; issue_addr = 3'd0;
        wr_data = 16'h0000; pc_in = 16'h0000;
        model_reset();
        #2 check_now("reset");
        #10 reset = 1'b1;
        @(posedge clk); #2;

        // writeback R3
        ra_addr = 3'd3; write = 1'b0; wr_addr = 3'd3; wr_data = 16'hBEEF;
        check_now("wr3_same");
        clock_step("wr3");

        // issue R5, then retire it
        rb_addr = 3'd5; issue = 1'b0; issue_addr = 3'd5;
        clock_step("issue5");
        write = 1'b0; wr_addr = 3'd5; wr_data = 16'h5A5A;
        check_now("wr5_same");
        clock_step("wr5");

        // same-cycle issue and write of R2
        ra_addr = 3'd2; issue = 1'b0; issue_addr = 3'd2;
        write = 1'b0; wr_addr = 3'd2; wr_data = 16'h2222;
        check_now("iw2_same");
        clock_step("iw2");

        // PC wrap and priority
        rb_addr = 3'd7; write = 1'b0; wr_addr = 3'd7; wr_data = 16'hFFFF;
        clock_step("r7_ffff");
        pc_inc = 1'b0;
        clock_step("pc_wrap");
        pc_inc = 1'b0; pc_write = 1'b0; pc_in = 16'h0100;
        write = 1'b0; wr_addr = 3'd7; wr_data = 16'h0200;
        check_now("pc_prio_same");
        clock_step("pc_prio");
        pc_inc = 1'b0; write = 1'b0; wr_addr = 3'd7; wr_data = 16'h0300;
        check_now("r7_wr_same");
        clock_step("r7_wr_over_inc");
        pc_inc = 1'b0;
        clock_step("pc_inc");

        // randomised traffic
        for (int n = 0; n < 60; n++) begin
            ra_addr    = 3'($urandom_range(7, 0));
            rb_addr    = 3'($urandom_range(7, 0));
            wr_addr    = 3'($urandom_range(7, 0));
            issue_addr = 3'($urandom_range(7, 0));
            wr_data    = 16'($urandom);
            pc_in      = 16'($urandom);
            write      = ($urandom_range(2, 0) != 0) ? 1'b0 : 1'b1;
            issue      = ($urandom_range(2, 0) == 0) ? 1'b0 : 1'b1;
            pc_write   = ($urandom_range(5, 0) == 0) ? 1'b0 : 1'b1;
            pc_inc     = ($urandom_range(1, 0) == 0) ? 1'b0 : 1'b1;
            check_now("rnd_same");
            clock_step("rnd");
        end

        // make sure some busy state is outstanding, then reset asynchronously mid-cycle
        issue = 1'b0; issue_addr = 3'd4; write = 1'b0; wr_addr = 3'd1; wr_data = 16'h1111;
        clock_step("pre_rst");
        ra_addr = 3'd1; rb_addr = 3'd4;
        #1 reset = 1'b0;
        model_reset();
        check_now("async_rst");
        write = 1'b0; wr_addr = 3'd1; wr_data = 16'hDEAD; pc_inc = 1'b0; issue = 1'b0;
        @(posedge clk); #2;
        idle();
        check_now("rst_held");
        reset = 1'b1;
        rb_addr = 3'd7;
        pc_inc = 1'b0;
        clock_step("post_rst_inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
